// File: rtl/im_ctrl_pkg.sv
// Shared types and helpers for the instruction-cache refill controller.
package im_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    CHECK  = 3'd2,
    AR     = 3'd3,
    REFILL = 3'd4,
    FINISH = 3'd5,
    FLUSH  = 3'd6
  } im_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bits needed to index a word inside a line.
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_im_ctrl_param_if.sv
// Read channel between the I-cache controller and the IM AXI read master.
// Handshake: arvalid rises with a valid read_addr_m/arlen and holds until the
// cycle arready=1; R beats carry no ready and are taken on every rvalid.
interface cache_im_ctrl_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] read_addr_m;
  logic [7:0]        arlen;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [1:0]        rresp;

  modport master (output arvalid, read_addr_m, arlen,
                  input  arready, rvalid, rdata, rlast, rresp);
  modport slave  (input  arvalid, read_addr_m, arlen,
                  output arready, rvalid, rdata, rlast, rresp);
endinterface

// File: rtl/im_refill_counter.sv
// Refill beat bookkeeping: beat index, write qualification, capture select
// and sticky bus-error flag for one line refill.
module im_refill_counter
  import im_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic             clear,
  input  logic [1:0]       rresp,
  input  logic [OFF_W-1:0] req_off,
  output logic [OFF_W-1:0] beat_cnt,
  output logic             write_en,
  output logic             capture,
  output logic             err_flag,
  output logic             line_full
);

  localparam logic [OFF_W:0] FULL = LINE_WORDS[OFF_W:0];
  localparam logic [OFF_W:0] ONE  = 1;

  // One extra bit counts beats past the line end; the count saturates at all-ones.
  logic [OFF_W:0] rcv_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcv_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clear) begin
      rcv_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (beat) begin
      if (rcv_cnt != '1) rcv_cnt <= rcv_cnt + ONE;
      if (rresp != RESP_OKAY) err_flag <= 1'b1;
    end
  end

  assign beat_cnt  = rcv_cnt[OFF_W] ? {OFF_W{1'b1}} : rcv_cnt[OFF_W-1:0];
  assign write_en  = beat && !rcv_cnt[OFF_W];
  assign capture   = write_en && (beat_cnt == req_off);
  assign line_full = (rcv_cnt == FULL);

endmodule

// File: rtl/cache_im_ctrl_param.sv
// Instruction-cache control FSM: hit delivery, single-burst line refill,
// bus-error substitution and whole-cache flush, yielding to DM stalls.
module cache_im_ctrl_param
  import im_ctrl_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              LINE_WORDS = 4,
  parameter logic [DATA_W-1:0] ERR_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              inst_valid,
  output logic              inst_err,
  output logic              cpu_im_stall,
  input  logic              dm_stall,
  input  logic              flush_req,
  output logic              flush_done,
  cache_im_ctrl_param_if.master axi,
  input  logic              hit,
  input  logic [DATA_W-1:0] read_data_c,
  output logic [ADDR_W-1:0] rw_addr_c,
  output logic [DATA_W-1:0] write_data_c,
  output logic              web_c,
  output logic              line_valid_set,
  output logic              inv_all,
  output logic              read_req_hit,
  output logic              read_req_miss_last,
  output im_state_e         state_dbg
);

  localparam int OFF_W = off_w(LINE_WORDS);

  im_state_e         state, state_nx, decide_nx;
  logic [DATA_W-1:0] inst_reg;
  logic [OFF_W-1:0]  beat_cnt;
  logic              beat, write_en, capture, err_flag, line_full;

  assign beat = (state == REFILL) && axi.rvalid;

  im_refill_counter #(.LINE_WORDS(LINE_WORDS), .OFF_W(OFF_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .beat     (beat),
    .clear    (state == FINISH),
    .rresp    (axi.rresp),
    .req_off  (pc[OFF_W+1:2]),
    .beat_cnt (beat_cnt),
    .write_en (write_en),
    .capture  (capture),
    .err_flag (err_flag),
    .line_full(line_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          inst_reg <= '0;
    else if (capture) inst_reg <= axi.rdata;
  end

  // Shared choice at every point where a new fetch may start.
  assign decide_nx = flush_req ? FLUSH :
                     (dm_stall || pc == '0) ? IDLE : ADDR;

  always_comb begin
    state_nx           = state;
    cpu_inst           = '0;
    inst_valid         = 1'b0;
    inst_err           = 1'b0;
    cpu_im_stall       = 1'b1;
    flush_done         = 1'b0;
    axi.arvalid        = 1'b0;
    rw_addr_c          = pc;
    web_c              = 1'b1;
    line_valid_set     = 1'b0;
    inv_all            = 1'b0;
    read_req_hit       = 1'b0;
    read_req_miss_last = 1'b0;
    case (state)
      IDLE: begin
        cpu_im_stall = dm_stall || (pc == '0);
        state_nx     = decide_nx;
      end
      ADDR: state_nx = CHECK;
      CHECK: begin
        if (hit) begin
          cpu_inst     = read_data_c;
          inst_valid   = 1'b1;
          read_req_hit = 1'b1;
          cpu_im_stall = 1'b0;
          state_nx     = decide_nx;
        end else begin
          state_nx = AR;
        end
      end
      AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nx = REFILL;
      end
      REFILL: begin
        rw_addr_c = {pc[ADDR_W-1:OFF_W+2], beat_cnt, 2'b00};
        web_c     = !write_en;
        if (beat && axi.rlast) state_nx = FINISH;
      end
      FINISH: begin
        inst_valid         = 1'b1;
        read_req_miss_last = 1'b1;
        cpu_im_stall       = 1'b0;
        cpu_inst           = err_flag ? ERR_INST : inst_reg;
        inst_err           = err_flag;
        line_valid_set     = !err_flag && line_full;
        state_nx           = decide_nx;
      end
      FLUSH: begin
        inv_all    = 1'b1;
        flush_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign axi.read_addr_m = {pc[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign axi.arlen       = 8'(LINE_WORDS - 1);
  assign write_data_c    = axi.rdata;
  assign state_dbg       = state;

endmodule

// File: tb/tb_cache_im_ctrl_param.sv
// Directed bench for cache_im_ctrl_param with 8-word lines: hit vectors from a
// table, then hand-written miss, error, burst-length, flush and reset sequences.
module tb_cache_im_ctrl_param;
  import im_ctrl_pkg::*;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] cpu_inst;
  logic        inst_valid, inst_err, cpu_im_stall;
  logic        dm_stall, flush_req, flush_done;
  logic        hit;
  logic [31:0] read_data_c, rw_addr_c, write_data_c;
  logic        web_c, line_valid_set, inv_all, read_req_hit, read_req_miss_last;
  im_state_e   state_dbg;

  int checks = 0;
  int errors = 0;

  cache_im_ctrl_param_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  cache_im_ctrl_param #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .cpu_inst(cpu_inst), .inst_valid(inst_valid),
    .inst_err(inst_err), .cpu_im_stall(cpu_im_stall), .dm_stall(dm_stall),
    .flush_req(flush_req), .flush_done(flush_done), .axi(axi), .hit(hit),
    .read_data_c(read_data_c), .rw_addr_c(rw_addr_c), .write_data_c(write_data_c),
    .web_c(web_c), .line_valid_set(line_valid_set), .inv_all(inv_all),
    .read_req_hit(read_req_hit), .read_req_miss_last(read_req_miss_last),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
    return {a[15:0], 8'hB0, 8'(i)};
  endfunction

  // Walk back to IDLE with pc=0 and a hit answer, bounded.
  task automatic to_idle();
    bit done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      pc = '0; hit = 1'b1; dm_stall = 1'b0; flush_req = 1'b0; axi.rvalid = 1'b0;
      #1;
      if (state_dbg == IDLE) done = 1'b1;
    end
    chk("to_idle", 32'(done), 32'd1);
    hit = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] a, input int nbeats, input int err_beat,
                         input int ar_dly, input bit exp_lvs, input bit flush_mid,
                         input bit rst_mid);
    logic [31:0] base, exp_inst;
    int off;
    bit exp_err;
    base     = a & ~32'(LW * 4 - 1);
    off      = int'((a >> 2) % LW);
    exp_inst = '0;
    exp_err  = (err_beat >= 0) && (err_beat < nbeats);
    @(negedge clk); pc = a; hit = 1'b0; dm_stall = 1'b0; #1;
    @(negedge clk); #1;
    chk("miss_addr_state", 32'(state_dbg), 32'(ADDR));
    @(negedge clk); #1;
    chk("miss_check_stall", 32'(cpu_im_stall), 32'd1);
    chk("miss_check_valid", 32'(inst_valid), 32'd0);
    for (int c = 0; c <= ar_dly; c++) begin
      @(negedge clk); axi.arready = (c == ar_dly); #1;
      chk("ar_valid_held", 32'(axi.arvalid), 32'd1);
      chk("ar_addr", axi.read_addr_m, base);
      chk("ar_len", 32'(axi.arlen), 32'(LW - 1));
    end
    for (int i = 0; i < nbeats; i++) begin
      if (i == 3) begin
        @(negedge clk); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
        chk("gap_web", 32'(web_c), 32'd1);
      end
      @(negedge clk);
      axi.arready = 1'b0;
      axi.rvalid  = 1'b1;
      axi.rdata   = beat_data(a, i);
      axi.rlast   = (i == nbeats - 1);
      axi.rresp   = (i == err_beat) ? 2'b10 : 2'b00;
      if (flush_mid && i == 1) flush_req = 1'b1;
      if (rst_mid && i == 2) begin
        rst = 1'b1; #1;
        chk("rst_mid_state", 32'(state_dbg), 32'(IDLE));
        chk("rst_mid_web", 32'(web_c), 32'd1);
        @(negedge clk); rst = 1'b0; pc = '0; axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
        chk("rst_mid_idle", 32'(state_dbg), 32'(IDLE));
        return;
      end
      #1;
      if (i == 0) chk("refill_arvalid_low", 32'(axi.arvalid), 32'd0);
      chk("beat_web", 32'(web_c), (i < LW) ? 32'd0 : 32'd1);
      chk("beat_wdata", write_data_c, beat_data(a, i));
      if (i < LW) chk("beat_waddr", rw_addr_c, base + 32'(4 * i));
      if (i == off) exp_inst = beat_data(a, i);
    end
    @(negedge clk); axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; #1;
    chk("fin_valid", 32'(inst_valid), 32'd1);
    chk("fin_miss_last", 32'(read_req_miss_last), 32'd1);
    chk("fin_stall", 32'(cpu_im_stall), 32'd0);
    chk("fin_err", 32'(inst_err), 32'(exp_err));
    chk("fin_inst", cpu_inst, exp_err ? 32'h00000013 : exp_inst);
    chk("fin_line_valid", 32'(line_valid_set), 32'(exp_lvs));
    chk("fin_flush_done", 32'(flush_done), 32'd0);
    if (flush_mid) begin
      @(negedge clk); flush_req = 1'b0; pc = '0; #1;
      chk("flush_state", 32'(state_dbg), 32'(FLUSH));
      chk("flush_inv_all", 32'(inv_all), 32'd1);
      chk("flush_done", 32'(flush_done), 32'd1);
      chk("flush_stall", 32'(cpu_im_stall), 32'd1);
      @(negedge clk); #1;
      chk("flush_to_idle", 32'(state_dbg), 32'(IDLE));
    end else begin
      to_idle();
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        dm;
    im_state_e   exp_next;
    logic        exp_stall;
  } hit_vec_t;

  hit_vec_t hv[4];

  initial begin
    hv[0] = '{pc: 32'h104, data: 32'h11112222, dm: 1'b0, exp_next: ADDR, exp_stall: 1'b1};
    hv[1] = '{pc: 32'h100, data: 32'hDEADBEEF, dm: 1'b0, exp_next: ADDR, exp_stall: 1'b1};
    hv[2] = '{pc: 32'h10C, data: 32'h00000000, dm: 1'b0, exp_next: ADDR, exp_stall: 1'b1};
    hv[3] = '{pc: 32'h108, data: 32'hCAFEF00D, dm: 1'b1, exp_next: IDLE, exp_stall: 1'b1};

    rst = 1'b1; pc = '0; dm_stall = 1'b0; flush_req = 1'b0; hit = 1'b0;
    read_data_c = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0;
    axi.rresp = 2'b00;

    @(negedge clk); #1;
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_stall", 32'(cpu_im_stall), 32'd1);
    chk("rst_web", 32'(web_c), 32'd1);
    chk("rst_inst", cpu_inst, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); pc = hv[i].pc; dm_stall = 1'b0; hit = 1'b0; #1;
      chk("hit_idle_stall", 32'(cpu_im_stall), 32'd0);
      @(negedge clk); #1;
      chk("hit_addr_stall", 32'(cpu_im_stall), 32'd1);
      chk("hit_addr_rw", rw_addr_c, hv[i].pc);
      @(negedge clk); hit = 1'b1; read_data_c = hv[i].data; dm_stall = hv[i].dm; #1;
      chk("hit_valid", 32'(inst_valid), 32'd1);
      chk("hit_inst", cpu_inst, hv[i].data);
      chk("hit_strobe", 32'(read_req_hit), 32'd1);
      chk("hit_no_ar", 32'(axi.arvalid), 32'd0);
      chk("hit_stall", 32'(cpu_im_stall), 32'd0);
      @(negedge clk); hit = 1'b0; #1;
      chk("hit_next_state", 32'(state_dbg), 32'(hv[i].exp_next));
      chk("hit_next_stall", 32'(cpu_im_stall), 32'(hv[i].exp_stall));
      if (hv[i].dm) begin
        @(negedge clk); #1;
        chk("dm_hold_state", 32'(state_dbg), 32'(IDLE));
        chk("dm_hold_stall", 32'(cpu_im_stall), 32'd1);
        @(negedge clk); dm_stall = 1'b0; #1;
        chk("dm_release_stall", 32'(cpu_im_stall), 32'd0);
        @(negedge clk); #1;
        chk("dm_release_addr", 32'(state_dbg), 32'(ADDR));
      end
      to_idle();
    end

    // Main miss, error, short burst, long burst, flush mid-refill.
    do_miss(32'h21C, 8, -1, 3, 1'b1, 1'b0, 1'b0);
    do_miss(32'h308, 8, 2, 0, 1'b0, 1'b0, 1'b0);
    do_miss(32'h308, 8, -1, 1, 1'b1, 1'b0, 1'b0);
    do_miss(32'h404, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    do_miss(32'h500, 10, -1, 0, 1'b0, 1'b0, 1'b0);
    do_miss(32'h600, 8, -1, 2, 1'b1, 1'b1, 1'b0);

    // Flush from IDLE.
    @(negedge clk); pc = '0; flush_req = 1'b1; #1;
    chk("idle_flush_pre", 32'(state_dbg), 32'(IDLE));
    @(negedge clk); flush_req = 1'b0; #1;
    chk("idle_flush_state", 32'(state_dbg), 32'(FLUSH));
    chk("idle_flush_inv", 32'(inv_all), 32'd1);
    @(negedge clk); #1;
    chk("idle_flush_back", 32'(state_dbg), 32'(IDLE));

    // Reset during refill, then a clean refill proves counters restarted.
    do_miss(32'h710, 8, -1, 0, 1'b0, 1'b0, 1'b1);
    do_miss(32'h714, 8, -1, 0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
